oisc8_infifo_block: RTL

Byte-stream input port for the oisc8 CPU. An external producer pushes bytes through a valid/ready handshake into an internal FIFO; the CPU pulls them by naming the block's data address as an instruction *source* on IBus. A second address exposes status (read) and flush control (write). The block is the bus-read counterpart of the existing write-only sink ports and sits beside `pc_block` and `alu_block` inside `oisc8_cpu`.

---
 rtl/oisc8_pkg.sv | 32 +++
 rtl/IBus.sv | 18 +
 rtl/sync_fifo.sv | 72 +++++++
 rtl/oisc8_infifo_block.sv | 79 +++++++
 4 files changed

// File: rtl/oisc8_pkg.sv
// Shared oisc8 definitions: IBus address map, instruction fields and
// the status/control bit positions of the input FIFO port.
package oisc8_pkg;

  // IBus source/destination addresses
  typedef enum logic [3:0] {
    NONE    = 4'd0,
    PC      = 4'd1,
    ALU_A   = 4'd2,
    ALU_B   = 4'd3,
    ALU_R   = 4'd4,
    IMM     = 4'd5,
    MEM     = 4'd6,
    UART    = 4'd7,
    LED     = 4'd8,
    INFIFO  = 4'd9,
    INFIFOS = 4'd10
  } bus_addr_e;

  typedef struct packed {
    bus_addr_e dst;
    bus_addr_e src;
  } instr_t;

  // Input FIFO status byte layout; count occupies bits [4:0]
  localparam int STAT_EMPTY = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_UDF   = 5;
  // Input FIFO control byte
  localparam int CTRL_FLUSH = 0;

endpackage

// File: rtl/IBus.sv
// oisc8 instruction bus. Read data is an OR of every source's
// contribution; unselected sources contribute zero.
interface IBus (
  input logic clk,
  input logic rst
);
  import oisc8_pkg::*;

  instr_t     instr;
  logic [7:0] data;
  logic [7:0] infifo_rd;  // contribution of the input FIFO port
  logic [7:0] host_rd;    // contribution of every other source

  assign data = infifo_rd | host_rd;

  modport infifo (input clk, rst, instr, data, output infifo_rd);
  modport host   (input clk, rst, data, infifo_rd, output instr, host_rd);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy counter. Pushes into a
// full FIFO and pops from an empty one are ignored; flush wins over both.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Next pointers and occupancy; simultaneous push and pop leave count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer/count state; reset discards any push or pop in that cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/oisc8_infifo_block.sv
// Byte-stream input port: producer pushes over valid/ready, the CPU pops
// by naming ADDR_DATA as source, and reads status / writes flush at ADDR_STAT.
module oisc8_infifo_block
  import oisc8_pkg::*;
#(
  parameter int        DEPTH     = 16,
  parameter bus_addr_e ADDR_DATA = INFIFO,
  parameter bus_addr_e ADDR_STAT = INFIFOS
) (
  IBus.infifo        bus,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          pop_sel, stat_sel, flush_now, push, pop;
  logic          udf_q, udf_d;
  logic [7:0]    stat;
  logic          unused_wdata;

  assign pop_sel   = (bus.instr.src == ADDR_DATA);
  assign stat_sel  = (bus.instr.src == ADDR_STAT);
  assign flush_now = (bus.instr.dst == ADDR_STAT) && bus.data[CTRL_FLUSH];
  assign in_ready  = !bus.rst && !full && !flush_now;
  assign push      = in_valid && in_ready;
  assign pop       = pop_sel && !empty;
  // Only the flush bit of a control write is meaningful
  assign unused_wdata = ^bus.data[7:1];

  sync_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (bus.clk),
    .rst_i   (bus.rst),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .flush_i (flush_now),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Status byte: flags on top, occupancy in the low five bits
  always_comb begin
    stat             = '0;
    stat[4:0]        = 5'(count);
    stat[STAT_EMPTY] = empty;
    stat[STAT_FULL]  = full;
    stat[STAT_UDF]   = udf_q;
  end

  // Read mux: head on pop (zero when empty), status, else no contribution
  always_comb begin
    bus.infifo_rd = 8'h00;
    if (pop_sel)       bus.infifo_rd = empty ? 8'h00 : head;
    else if (stat_sel) bus.infifo_rd = stat;
  end

  // Sticky underflow: cleared by a status read, but a same-cycle underflow wins
  always_comb begin
    udf_d = udf_q;
    if (stat_sel)          udf_d = 1'b0;
    if (pop_sel && empty)  udf_d = 1'b1;
  end

  // Underflow flag register
  always_ff @(posedge bus.clk) begin
    if (bus.rst) udf_q <= 1'b0;
    else         udf_q <= udf_d;
  end

endmodule
